fifo_width_downsizer: RTL

Drains a show-ahead FIFO of IN_WIDTH-bit words (q valid whenever empty is low, rdreq pops) and emits each word as RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream. It sits directly downstream of the soft/BRAM FIFO in the DRAM-read return path, feeding narrow application ports. Beats leave least-significant slice first. out_last marks the final beat of every WORDS_PER_PKT-word packet. Sustained throughput is one beat per cycle, with no bubble between words.

---
 rtl/fifo_width_downsizer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_width_downsizer.sv
// fifo_width_downsizer: pulls IN_WIDTH-bit words from a show-ahead FIFO and
// replays each one as RATIO narrow beats on a valid/ready stream. The least
// significant slice goes first. out_last flags the final beat of every
// WORDS_PER_PKT-word packet. The next word is loaded in the same cycle as
// the current word's final beat, so a busy stream has no idle cycles
// between words.
module fifo_width_downsizer #(
  parameter int IN_WIDTH      = 512,
  parameter int OUT_WIDTH     = 64,
  parameter int WORDS_PER_PKT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CNT_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] PKT_MAX = CNT_W'(WORDS_PER_PKT - 1);

  // Reject parameter sets that cannot be sliced evenly into a power-of-two
  // number of beats, or that describe an empty packet.
  generate
    if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
      $error("fifo_width_downsizer: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
    end
    if (WORDS_PER_PKT < 1) begin : g_bad_pkt
      $error("fifo_width_downsizer: WORDS_PER_PKT must be at least 1");
    end
  endgenerate

  // The held-word flag is the whole state machine: EMPTY means nothing is
  // held, and SERVE means a word is being sliced out.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IN_WIDTH-1:0]   hold_data_q;
  logic [IN_WIDTH-1:0]   hold_data_d;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_d;
  logic [CNT_W-1:0]      pkt_cnt_q;
  logic [CNT_W-1:0]      pkt_cnt_d;

  logic                  hold_valid;
  logic                  take;
  logic                  last_slice;
  logic                  final_beat;
  logic                  pkt_end;
  logic [OUT_WIDTH-1:0]  slice_w [RATIO];

  // Break the held word into its beat-sized slices, then pick the slice sel_q
  // points at.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slice_w[gi] = hold_data_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // Handshake qualifiers plus the pop decision. A pop is allowed only when
  // the FIFO is not empty. It happens when the hold register is free, or in
  // the cycle it is being freed.
  always_comb begin
    hold_valid = (state_q == ST_SERVE);
    take       = hold_valid & out_ready;
    last_slice = (sel_q == SEL_MAX);
    final_beat = take & last_slice;
    pkt_end    = (pkt_cnt_q == PKT_MAX);
    fifo_rdreq = ~reset & ~fifo_empty & (~hold_valid | final_beat);
  end

  // Stream outputs come straight from the held word and the counters, so
  // they stay put while the sink stalls.
  always_comb begin
    out_valid = hold_valid;
    out_data  = slice_w[sel_q];
    out_last  = hold_valid & last_slice & pkt_end;
  end

  // Next-state logic. A load wins over the drain-to-EMPTY case, because the
  // final beat and the next pop share a cycle when traffic is back-to-back.
  // sel goes back to 0 by reload and never wraps by counting.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    sel_d       = sel_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (fifo_rdreq) begin
      state_d     = ST_SERVE;
      hold_data_d = fifo_q;
      sel_d       = '0;
    end else if (final_beat) begin
      state_d = ST_EMPTY;
      sel_d   = '0;
    end else if (take) begin
      sel_d = sel_q + SEL_W'(1);
    end

    if (final_beat) begin
      pkt_cnt_d = pkt_end ? '0 : (pkt_cnt_q + CNT_W'(1));
    end
  end

  // Control state register. Reset drops any partly sent word, because it was
  // already popped and cannot be recovered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      sel_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Data-only holding register. It has no reset, because nothing reads it
  // unless hold_valid is set.
  always_ff @(posedge clock) begin
    hold_data_q <= hold_data_d;
  end

endmodule
